// File: rtl/ext_pipe_if.sv
// ext_pipe_if: handshake bundle between the decode-stage immediate mux
// (master) and the ext_pipe extender (slave). The consumer-side out_ready
// is driven by the master side so a single bench/parent owns both ends.
interface ext_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_boff;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;

    modport master (
        output in_valid, in_data, in_boff, in_op, out_ready,
        input  in_ready, out_valid, out_data, occ
    );

    modport slave (
        input  in_valid, in_data, in_boff, in_op, out_ready,
        output in_ready, out_valid, out_data, occ
    );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate/data extender with a 2-entry skid buffer.
// Main reg M drives out_data, skid reg S absorbs one beat of backpressure,
// so in_ready is purely registered and 1 result/cycle is sustained.
// Optional macro EXT_PIPE_LOAD_EXT_EN adds load-data modes LB/LBU/LH/LHU.
module ext_pipe #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    ext_pipe_if.slave   bus
);
    localparam logic [OP_W-1:0] OP_ZERO = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ZEXT = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SEXT = OP_W'(2);
    localparam logic [OP_W-1:0] OP_HIGH = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(4);
`ifdef EXT_PIPE_LOAD_EXT_EN
    localparam logic [OP_W-1:0] OP_LB   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LBU  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_LH   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LHU  = OP_W'(8);
`endif

    // Parameter sanity checks at elaboration
    if (DATA_W <= IMM_W + 2) begin : g_chk_width
        $error("ext_pipe: DATA_W must exceed IMM_W+2");
    end
`ifdef EXT_PIPE_LOAD_EXT_EN
    if (DATA_W != 32) begin : g_chk_load
        $error("ext_pipe: load modes require DATA_W == 32");
    end
`endif

    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_result;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_m_v_n;
    logic              w_s_v_n;
    logic              w_m_ld;
    logic              w_s_ld;
    logic [DATA_W-1:0] w_m_d_n;

    logic              r_m_v;
    logic              r_s_v;
    logic [DATA_W-1:0] r_m_d;
    logic [DATA_W-1:0] r_s_d;
    logic [1:0]        r_occ;
    logic              r_in_ready;

    assign w_imm      = bus.in_data[IMM_W-1:0];
    assign w_sext     = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_m_v & bus.out_ready;

`ifdef EXT_PIPE_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select for load modes
    always_comb begin
        w_byte = bus.in_data[7:0];
        case (bus.in_boff)
            2'd0:    w_byte = bus.in_data[7:0];
            2'd1:    w_byte = bus.in_data[15:8];
            2'd2:    w_byte = bus.in_data[23:16];
            default: w_byte = bus.in_data[31:24];
        endcase
        w_half = bus.in_boff[1] ? bus.in_data[31:16] : bus.in_data[15:0];
    end
`endif

    // Extension result for the presented input
    always_comb begin
        w_result = '0;
        case (bus.in_op)
            OP_ZERO: w_result = '0;
            OP_ZEXT: w_result = DATA_W'(w_imm);
            OP_SEXT: w_result = w_sext;
            OP_HIGH: w_result = {w_imm, {(DATA_W-IMM_W){1'b0}}};
            OP_BR:   w_result = w_sext << 2;
`ifdef EXT_PIPE_LOAD_EXT_EN
            OP_LB:   w_result = {{(DATA_W-8){w_byte[7]}}, w_byte};
            OP_LBU:  w_result = DATA_W'(w_byte);
            OP_LH:   w_result = bus.in_boff[0] ? '0 : {{(DATA_W-16){w_half[15]}}, w_half};
            OP_LHU:  w_result = bus.in_boff[0] ? '0 : DATA_W'(w_half);
`endif
            default: w_result = '0;
        endcase
    end

    // Next-state of the M/S skid pair
    always_comb begin
        w_m_v_n = r_m_v;
        w_s_v_n = r_s_v;
        w_m_ld  = 1'b0;
        w_s_ld  = 1'b0;
        w_m_d_n = w_result;
        if (flush) begin
            w_m_v_n = 1'b0;
            w_s_v_n = 1'b0;
        end else if (!r_m_v) begin
            if (w_in_fire) begin
                w_m_v_n = 1'b1;
                w_m_ld  = 1'b1;
            end
        end else if (w_out_fire) begin
            if (r_s_v) begin
                w_m_v_n = 1'b1;
                w_m_ld  = 1'b1;
                w_m_d_n = r_s_d;
                w_s_v_n = w_in_fire;
                w_s_ld  = w_in_fire;
            end else begin
                w_m_v_n = w_in_fire;
                w_m_ld  = w_in_fire;
            end
        end else if (w_in_fire) begin
            w_s_v_n = 1'b1;
            w_s_ld  = 1'b1;
        end
    end

    // Valid bits and derived registered status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_v      <= 1'b0;
            r_s_v      <= 1'b0;
            r_occ      <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_m_v      <= w_m_v_n;
            r_s_v      <= w_s_v_n;
            r_occ      <= {1'b0, w_m_v_n} + {1'b0, w_s_v_n};
            r_in_ready <= !w_s_v_n;
        end
    end

    // Data registers load only with their valid bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_d <= '0;
            r_s_d <= '0;
        end else begin
            if (w_m_ld) r_m_d <= w_m_d_n;
            if (w_s_ld) r_s_d <= w_result;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_m_v;
    assign bus.out_data  = r_m_d;
    assign bus.occ       = r_occ;
endmodule
